// File: rtl/demux2_reg_pkg.sv
// Shared definitions for the registered 1:2 demultiplexer: destination encoding,
// default widths and the alternating-pointer helper.
package demux2_reg_pkg;

    typedef enum logic {
        DEST_O0 = 1'b0,
        DEST_O1 = 1'b1
    } dest_e;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 8;

    function automatic dest_e toggle_dest(input dest_e d);
        return (d == DEST_O0) ? DEST_O1 : DEST_O0;
    endfunction

endpackage

// File: rtl/demux2_reg_if.sv
// Bundle of the input stream, the two output streams and the debug counters.
// The slave modport is the demux itself; master is whoever drives and drains it.
interface demux2_reg_if
    import demux2_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic [WIDTH-1:0] i;
    logic             i_valid;
    logic             i_ready;
    logic             j;
    logic             alt_mode;
    logic [WIDTH-1:0] o0;
    logic             o0_valid;
    logic             o0_ready;
    logic [WIDTH-1:0] o1;
    logic             o1_valid;
    logic             o1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  i, i_valid, j, alt_mode, o0_ready, o1_ready,
        output i_ready, o0, o0_valid, o1, o1_valid, cnt0, cnt1
    );

    modport master (
        output i, i_valid, j, alt_mode, o0_ready, o1_ready,
        input  i_ready, o0, o0_valid, o1, o1_valid, cnt0, cnt1
    );

endinterface

// File: rtl/demux2_reg_out_slot.sv
// One-entry valid/ready holding register with a wrapping delivery counter.
// A load in the same cycle as a delivery refills the slot for full throughput.
module demux2_reg_out_slot
    import demux2_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             can_load_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             deliver;

    assign deliver    = valid_q && ready_i;
    assign can_load_o = !valid_q || ready_i;

    // Data is only rewritten on load, so it stays stable while stalled.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (deliver) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/demux2_reg.sv
// Registered 1:2 demultiplexer: each accepted word goes to output 0 or 1, picked
// by j or by an alternating pointer, and is held in that output's slot.
module demux2_reg
    import demux2_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input logic         clk,
    input logic         rst_n,
    demux2_reg_if.slave bus
);

    dest_e dest;
    dest_e ptr_q, ptr_d;
    logic  can0, can1;
    logic  accept;
    logic  load0, load1;

    assign dest        = bus.alt_mode ? ptr_q : dest_e'(bus.j);
    assign bus.i_ready = (dest == DEST_O1) ? can1 : can0;
    assign accept      = bus.i_valid && bus.i_ready;
    assign load0       = accept && (dest == DEST_O0);
    assign load1       = accept && (dest == DEST_O1);

    // The pointer only advances on accepts made in alternating mode.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && bus.alt_mode) begin
            ptr_d = toggle_dest(ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= DEST_O0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    demux2_reg_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load0),
        .load_data_i (bus.i),
        .ready_i     (bus.o0_ready),
        .data_o      (bus.o0),
        .valid_o     (bus.o0_valid),
        .can_load_o  (can0),
        .count_o     (bus.cnt0)
    );

    demux2_reg_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load1),
        .load_data_i (bus.i),
        .ready_i     (bus.o1_ready),
        .data_o      (bus.o1),
        .valid_o     (bus.o1_valid),
        .can_load_o  (can1),
        .count_o     (bus.cnt1)
    );

endmodule

// File: tb/tb_demux2_reg.sv
// Directed plus short random test of demux2_reg against a queue-based scoreboard
// holding the words each output still owes downstream.
module tb_demux2_reg;

    logic clk = 1'b0;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    logic [0:0] sb0[$];
    logic [0:0] sb1[$];
    logic       mPtr;
    logic [7:0] mCnt0;
    logic [7:0] mCnt1;
    bit         mKnown = 1'b0;
    logic       expDest;
    logic       expRdy;

    demux2_reg_if #(.WIDTH(1), .CNT_W(8)) bus ();

    demux2_reg #(.WIDTH(1), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares DUT outputs with the scoreboard for the inputs currently driven.
    task automatic checkOutput();
        expDest = bus.alt_mode ? mPtr : bus.j;
        expRdy  = expDest ? (sb1.size() == 0 || bus.o1_ready)
                          : (sb0.size() == 0 || bus.o0_ready);
        if (mKnown) begin
            checkEq("i_ready", 32'(bus.i_ready), 32'(expRdy));
            checkEq("o0_valid", 32'(bus.o0_valid), 32'(sb0.size() != 0));
            checkEq("o1_valid", 32'(bus.o1_valid), 32'(sb1.size() != 0));
            if (sb0.size() != 0) checkEq("o0_data", 32'(bus.o0), 32'(sb0[0]));
            if (sb1.size() != 0) checkEq("o1_data", 32'(bus.o1), 32'(sb1[0]));
            checkEq("cnt0", 32'(bus.cnt0), 32'(mCnt0));
            checkEq("cnt1", 32'(bus.cnt1), 32'(mCnt1));
        end
    endtask

    // Drives one cycle of inputs at the falling edge, checks, then advances the model.
    task automatic applyStimulus(input logic rn, input logic iv, input logic id,
                                 input logic jj, input logic alt,
                                 input logic r0, input logic r1);
        rst_n        = rn;
        bus.i_valid  = iv;
        bus.i        = id;
        bus.j        = jj;
        bus.alt_mode = alt;
        bus.o0_ready = r0;
        bus.o1_ready = r1;
        #1;
        checkOutput();
        if (!rn) begin
            sb0.delete();
            sb1.delete();
            mPtr   = 1'b0;
            mCnt0  = 8'd0;
            mCnt1  = 8'd0;
            mKnown = 1'b1;
        end else if (mKnown) begin
            if (sb0.size() != 0 && r0) begin
                void'(sb0.pop_front());
                mCnt0++;
            end
            if (sb1.size() != 0 && r1) begin
                void'(sb1.pop_front());
                mCnt1++;
            end
            if (iv && expRdy) begin
                if (expDest) sb1.push_back(id);
                else         sb0.push_back(id);
                if (alt) mPtr = ~mPtr;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i        = 1'b0;
        bus.j        = 1'b0;
        bus.alt_mode = 1'b0;
        bus.o0_ready = 1'b0;
        bus.o1_ready = 1'b0;
        @(negedge clk);

        // Reset held for two cycles with a word offered.
        applyStimulus(0, 1, 1, 0, 0, 1, 1);
        applyStimulus(0, 1, 1, 0, 0, 1, 1);
        checkEq("rst_o0", 32'(bus.o0), 32'd0);
        checkEq("rst_o1", 32'(bus.o1), 32'd0);
        checkEq("rst_o0_valid", 32'(bus.o0_valid), 32'd0);
        checkEq("rst_o1_valid", 32'(bus.o1_valid), 32'd0);
        checkEq("rst_cnt0", 32'(bus.cnt0), 32'd0);
        checkEq("rst_cnt1", 32'(bus.cnt1), 32'd0);
        rst_n       = 1'b1;
        bus.i_valid = 1'b0;
        #1;
        checkEq("rst_release_i_ready", 32'(bus.i_ready), 32'd1);

        // Direct routing by j.
        applyStimulus(1, 1, 1, 0, 0, 1, 1);
        applyStimulus(1, 1, 0, 1, 0, 1, 1);
        applyStimulus(1, 1, 1, 1, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1);
        checkEq("dir_cnt0", 32'(bus.cnt0), 32'd1);
        checkEq("dir_cnt1", 32'(bus.cnt1), 32'd2);

        // Backpressure on output 0.
        applyStimulus(1, 1, 1, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkEq("bp_o0", 32'(bus.o0), 32'd0);
        checkEq("bp_o0_valid", 32'(bus.o0_valid), 32'd1);

        // Output 1 keeps flowing while output 0 stays stalled.
        applyStimulus(1, 1, 1, 1, 0, 0, 1);
        applyStimulus(1, 1, 0, 1, 0, 0, 1);
        applyStimulus(1, 1, 1, 1, 0, 0, 1);
        applyStimulus(1, 1, 1, 1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1);

        // Alternating mode with j stuck at 0, then back to direct routing.
        applyStimulus(1, 1, 1, 0, 1, 1, 1);
        applyStimulus(1, 1, 0, 0, 1, 1, 1);
        applyStimulus(1, 1, 0, 0, 1, 1, 1);
        applyStimulus(1, 1, 1, 0, 1, 1, 1);
        applyStimulus(1, 1, 1, 1, 0, 1, 1);
        applyStimulus(1, 1, 0, 1, 1, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1);

        // Random traffic with random readiness and mode changes.
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        applyStimulus(1, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1);

        // Counter wrap on output 1 after 256 deliveries.
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 256; k++) begin
            logic [31:0] kv;
            kv = 32'(k);
            applyStimulus(1, 1, kv[0], 1, 0, 1, 1);
            if (k == 254) checkEq("wrap_cnt1_pre", 32'(bus.cnt1), 32'd254);
        end
        applyStimulus(1, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1);
        checkEq("wrap_cnt1", 32'(bus.cnt1), 32'd0);

        // Reset while output 0 holds an undelivered word.
        applyStimulus(1, 1, 1, 0, 0, 0, 1);
        checkEq("mid_o0_valid", 32'(bus.o0_valid), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkEq("mid_o0_valid_after", 32'(bus.o0_valid), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1);
        checkEq("mid_cnt0", 32'(bus.cnt0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux2_reg.md
Name: demux2_reg

Overview:
- Registered 1:2 demultiplexer. It is the distribution-side counterpart of the team's 2:1 mux: one input stream, two output streams.
- Each accepted input word is routed to output 0 or output 1, chosen either by a select bit or by an internal alternating pointer.
- Each output has a one-entry holding register with valid/ready flow control.
- Per-output delivery counters are provided for debug and verification.

Parameters:
- WIDTH, 1, data width of the input and both outputs.
- CNT_W, 8, width of each per-output delivery counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- i  input  WIDTH  input data word.
- i_valid  input  1  input word present.
- i_ready  output  1  block can accept the input word this cycle.
- j  input  1  destination select; 0 = output 0, 1 = output 1. Used only when alt_mode=0.
- alt_mode  input  1  1 = destination taken from the internal alternating pointer; j is ignored.
- o0  output  WIDTH  output 0 data.
- o0_valid  output  1  output 0 holds an undelivered word.
- o0_ready  input  1  downstream 0 accepts the word.
- o1  output  WIDTH  output 1 data.
- o1_valid  output  1  output 1 holds an undelivered word.
- o1_ready  input  1  downstream 1 accepts the word.
- cnt0  output  CNT_W  count of words delivered on output 0.
- cnt1  output  CNT_W  count of words delivered on output 1.

Behaviour:
- Reset: when rst_n=0 at a rising clk edge, the following all clear to 0: o0, o1, o0_valid, o1_valid, cnt0, cnt1, and pointer ptr.
- Reset mid-operation discards any held words; no partial delivery.
- i_ready is combinational and depends only on current-cycle state. It does not depend on i_valid.
- Destination: dest = alt_mode ? ptr : j. It is evaluated combinationally each cycle.
- i_ready = !oD_valid || oD_ready, where D = dest. The non-selected output has no effect on i_ready.
- Accept: occurs when i_valid && i_ready. Next edge: oD <= i, oD_valid <= 1. Latency is exactly 1 cycle from accept to oD_valid.
- Deliver: occurs when oX_valid && oX_ready.
  - Next edge: oX_valid <= 0, unless the same cycle also accepts into X; then oX_valid stays 1 and oX takes the new word.
  - Same-cycle deliver and accept on one output gives full throughput: 1 word/cycle to that output.
- Held data: oX is stable while oX_valid=1 and oX_ready=0. Downstream may rely on this.
- Non-selected output: keeps its word and valid flag and drains independently via its own ready.
- Pointer (ptr, 1 bit):
  - Toggles on every accept while alt_mode=1.
  - Unchanged on accepts while alt_mode=0.
  - Unchanged on cycles with no accept.
- alt_mode may change on any cycle. The new value takes effect for dest in that same cycle.
- Counters:
  - cntX increments by 1 on every deliver on X.
  - Wraps modulo 2^CNT_W: 8'hFF + 1 -> 8'h00, no saturation, no flag.
- Invalid data: i is ignored when i_valid=0. oX contents after delivery are don't-care; the implementation retains the last value.
- No combinational path from i or i_valid to any output. The only combinational path is oX_ready/j/alt_mode -> i_ready.

Decomposition:
- Shared package:
  - DEST_O0 = 1'b0, DEST_O1 = 1'b1.
  - Default WIDTH and CNT_W constants.
- Sub-module out_slot (one-entry valid/ready holding register plus its delivery counter), instantiated twice.
  - Inputs: load, load data, ready.
  - Outputs: data, valid, can_load, count.
- Top level contains only dest selection, ptr, and the i_ready mux.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with i_valid=1, i=1 -> all outputs 0, cnt0=cnt1=0. Release -> i_ready=1.
- Direct routing: alt_mode=0, both readys=1, send 1,0,1 with j=0,1,1 -> o0 gets 1 and o1 gets 0 then 1, each 1 cycle after accept; cnt0=1, cnt1=2.
- Backpressure: j=0, o0_ready=0, send word 1 -> o0_valid=1, then i_ready=0 and word 0 stalls. Raise o0_ready -> word 1 delivered and word 0 accepted in the same cycle; o0=0 on the next cycle. o1 is unaffected throughout.
- Independent drain: o0 full and stalled, j=1, o1_ready=1 -> i_ready=1 and words flow to o1 every cycle while o0 holds its data unchanged.
- Alternating mode: alt_mode=1, j stuck at 0, send 4 words A,B,C,D -> A,C on o0 and B,D on o1. ptr returns to 0. Switching alt_mode=0 with j=1 routes the next word to o1.
- Wrap and reset mid-op: CNT_W=8, deliver 256 words on o1 -> cnt1 == 0. Assert rst_n=0 while o0_valid=1 -> o0_valid=0 next edge and the word is never delivered.
